// File: rtl/cp0_irq_vec_pkg.sv
// Shared CP0 definitions: operation codes, register addresses, STATUS/CAUSE field positions
// and the redirect target helper.
package cp0_irq_vec_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_MFC0 = 2'b01,
    OP_MTC0 = 2'b10,
    OP_ERET = 2'b11
  } cp0_op_e;

  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;
  localparam logic [4:0] REG_BASE   = 5'd15;

  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  localparam int ST_VEC = 2;
  localparam int IM_LSB = 8;
  localparam int IP_LSB = 8;
  localparam int CODE_W = 4;

  // Non-vectored dispatch always lands on BASE; vectored dispatch spaces slots by 2**shift bytes.
  function automatic logic [31:0] vec_target(input logic [31:0] base,
                                             input logic [CODE_W-1:0] idx,
                                             input logic vec,
                                             input int shift);
    return vec ? base + (32'(idx) << shift) : base;
  endfunction

endpackage

// File: rtl/cp0_irq_vec_line_sync.sv
// One interrupt line: synchroniser chain, then either a level pass-through or a
// rising-edge pending flop with write-one-to-clear (a same-cycle set beats the clear).
module cp0_irq_vec_line_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic ir_in,
  input  logic clr,
  output logic ip
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], ir_in};
  end

  if (EDGE) begin : g_edge
    logic prev_q;
    logic pend_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        prev_q <= 1'b0;
        pend_q <= 1'b0;
      end else begin
        prev_q <= sync_q[SYNC_STAGES-1];
        pend_q <= (sync_q[SYNC_STAGES-1] & ~prev_q) | (pend_q & ~clr);
      end
    end

    assign ip = pend_q;
  end else begin : g_level
    // Level lines have no storage, so a clear request has nothing to act on.
    logic unused_clr;
    assign unused_clr = clr;
    assign ip = sync_q[SYNC_STAGES-1];
  end

endmodule

// File: rtl/cp0_irq_vec.sv
// CP0 with IRQ_NUM external interrupt lines: per-line mask and mode, fixed priority
// (line 0 highest), optional vectored dispatch, EPC/ERET handling.
module cp0_irq_vec
  import cp0_irq_vec_pkg::*;
#(
  parameter int                 IRQ_NUM     = 8,
  parameter logic [IRQ_NUM-1:0] IRQ_EDGE    = '0,
  parameter int                 VEC_SHIFT   = 5,
  parameter logic [31:0]        RESET_BASE  = 32'h0000_0020,
  parameter int                 SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         oper,
  input  logic [4:0]         addr_r,
  output logic [31:0]        data_r,
  input  logic [4:0]         addr_w,
  input  logic [31:0]        data_w,
  input  logic               ir_en,
  input  logic [IRQ_NUM-1:0] ir_in,
  input  logic [31:0]        ret_addr,
  output logic               jump_en,
  output logic [31:0]        jump_addr,
  output logic [3:0]         irq_idx
);

  logic               ie;
  logic               exl;
  logic               vec;
  logic [IRQ_NUM-1:0] im;
  logic [31:0]        epc;
  logic [31:0]        base;

  logic [IRQ_NUM-1:0] ip;
  logic [IRQ_NUM-1:0] clr;
  logic [IRQ_NUM-1:0] active;
  logic [3:0]         win_idx;
  logic               is_eret;
  logic               is_mtc0;
  logic               wr_status;
  logic               wr_cause;
  logic               wr_epc;
  logic               wr_base;
  logic               take;
  logic [31:0]        status_word;
  logic [31:0]        cause_word;

  assign is_eret   = (oper == OP_ERET);
  assign is_mtc0   = (oper == OP_MTC0);
  assign wr_status = is_mtc0 && (addr_w == REG_STATUS);
  assign wr_cause  = is_mtc0 && (addr_w == REG_CAUSE);
  assign wr_epc    = is_mtc0 && (addr_w == REG_EPC);
  assign wr_base   = is_mtc0 && (addr_w == REG_BASE);

  assign clr = wr_cause ? data_w[IP_LSB +: IRQ_NUM] : '0;

  for (genvar i = 0; i < IRQ_NUM; i++) begin : g_line
    cp0_irq_vec_line_sync #(
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE        (IRQ_EDGE[i])
    ) u_line (
      .clk   (clk),
      .rst   (rst),
      .ir_in (ir_in[i]),
      .clr   (clr[i]),
      .ip    (ip[i])
    );
  end

  assign active = ip & im;

  // Scan from the top so the lowest active index is the one left standing.
  always_comb begin
    win_idx = '0;
    for (int i = IRQ_NUM - 1; i >= 0; i--) begin
      if (active[i]) win_idx = 4'(i);
    end
  end

  // ERET suppresses a take on the same edge; the line is looked at again next cycle.
  assign take = ir_en && ie && !exl && (|active) && !is_eret;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ie        <= 1'b0;
      exl       <= 1'b0;
      vec       <= 1'b0;
      im        <= '0;
      epc       <= '0;
      base      <= RESET_BASE;
      irq_idx   <= '0;
      jump_en   <= 1'b0;
      jump_addr <= '0;
    end else begin
      if (wr_status) begin
        ie  <= data_w[ST_IE];
        exl <= data_w[ST_EXL];
        vec <= data_w[ST_VEC];
        im  <= data_w[IM_LSB +: IRQ_NUM];
      end
      if (wr_epc)  epc  <= data_w;
      if (wr_base) base <= data_w;
      if (is_eret) exl  <= 1'b0;
      // Hardware take overrides a software write to EXL/EPC on the same edge.
      if (take) begin
        exl     <= 1'b1;
        epc     <= ret_addr;
        irq_idx <= win_idx;
      end
      jump_en <= take | is_eret;
      if (is_eret)   jump_addr <= epc;
      else if (take) jump_addr <= vec_target(base, win_idx, vec, VEC_SHIFT);
      else           jump_addr <= '0;
    end
  end

  always_comb begin
    status_word = '0;
    status_word[ST_IE]  = ie;
    status_word[ST_EXL] = exl;
    status_word[ST_VEC] = vec;
    status_word[IM_LSB +: IRQ_NUM] = im;

    cause_word = '0;
    cause_word[IP_LSB +: IRQ_NUM] = ip;
    cause_word[CODE_W-1:0] = irq_idx;

    data_r = '0;
    case (addr_r)
      REG_STATUS: data_r = status_word;
      REG_CAUSE:  data_r = cause_word;
      REG_EPC:    data_r = epc;
      REG_BASE:   data_r = base;
      default:    data_r = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_irq_vec.sv
// Bench for cp0_irq_vec: directed scenarios plus a random phase, checked against a
// queue-based behavioural model; redirect pulses are checked by a negedge monitor.
module tb_cp0_irq_vec;

  localparam int         N  = 8;
  localparam int         S  = 2;
  localparam int         VS = 5;
  localparam logic [7:0] EDGE_MASK = 8'h04;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  oper;
  logic [4:0]  addr_r;
  logic [31:0] data_r;
  logic [4:0]  addr_w;
  logic [31:0] data_w;
  logic        ir_en;
  logic [7:0]  ir_in;
  logic [31:0] ret_addr;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic [3:0]  irq_idx;

  cp0_irq_vec #(
    .IRQ_NUM     (N),
    .IRQ_EDGE    (EDGE_MASK),
    .VEC_SHIFT   (VS),
    .RESET_BASE  (32'h0000_0020),
    .SYNC_STAGES (S)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .oper      (oper),
    .addr_r    (addr_r),
    .data_r    (data_r),
    .addr_w    (addr_w),
    .data_w    (data_w),
    .ir_en     (ir_en),
    .ir_in     (ir_in),
    .ret_addr  (ret_addr),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .irq_idx   (irq_idx)
  );

  always #10 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  idx;
  } jmp_t;

  jmp_t        exp_q[$];
  bit          m_ie, m_exl, m_vec;
  bit [7:0]    m_im, m_pend;
  bit [3:0]    m_idx;
  bit [31:0]   m_epc, m_base;
  bit [7:0]    m_hist[$];   // m_hist[k] = ir_in sampled k edges ago

  function automatic void model_reset();
    m_ie = 0; m_exl = 0; m_vec = 0; m_im = 0; m_pend = 0; m_idx = 0;
    m_epc = 0; m_base = 32'h20;
    m_hist.delete();
    for (int i = 0; i < S + 2; i++) m_hist.push_back(8'h00);
  endfunction

  function automatic bit [3:0] lowest_set(input bit [7:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return 4'(i);
    return 4'd0;
  endfunction

  function automatic bit [31:0] model_read(input bit [4:0] a);
    bit [7:0] ipv;
    ipv = (m_pend & EDGE_MASK) | (m_hist[S-1] & ~EDGE_MASK);
    case (a)
      5'd12:   return {16'h0, m_im, 5'h0, m_vec, m_exl, m_ie};
      5'd13:   return {16'h0, ipv, 4'h0, m_idx};
      5'd14:   return m_epc;
      5'd15:   return m_base;
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_step(input bit [1:0] op, input bit [4:0] aw, input bit [31:0] dw,
                                     input bit en, input bit [31:0] ra, input bit [7:0] ir);
    bit [7:0]  lvl, prv, ipv, act, clrv;
    bit [3:0]  w;
    bit        tk;
    jmp_t      e;
    m_hist.push_front(ir);
    while (m_hist.size() > S + 2) void'(m_hist.pop_back());
    lvl = m_hist[S];
    prv = m_hist[S+1];
    ipv = (m_pend & EDGE_MASK) | (lvl & ~EDGE_MASK);
    act = ipv & m_im;
    w   = lowest_set(act);
    tk  = en && m_ie && !m_exl && (act != 0) && (op != 2'b11);
    if (op == 2'b11) begin
      e.addr = m_epc; e.idx = m_idx; exp_q.push_back(e);
    end else if (tk) begin
      e.addr = m_vec ? m_base + (32'(w) << VS) : m_base; e.idx = w; exp_q.push_back(e);
    end
    clrv   = (op == 2'b10 && aw == 5'd13) ? dw[15:8] : 8'h00;
    m_pend = ((lvl & ~prv) | (m_pend & ~clrv)) & EDGE_MASK;
    if (op == 2'b10) begin
      case (aw)
        5'd12: begin m_ie = dw[0]; m_exl = dw[1]; m_vec = dw[2]; m_im = dw[15:8]; end
        5'd14: m_epc = dw;
        5'd15: m_base = dw;
        default: ;
      endcase
    end
    if (op == 2'b11) m_exl = 0;
    if (tk) begin m_exl = 1; m_epc = ra; m_idx = w; end
  endfunction

  // ---------------- monitor ----------------
  bit mon_on = 0;
  jmp_t mon_e;

  always @(negedge clk) begin
    if (mon_on) begin
      if (jump_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_jump: jump_en=1 addr %h, no redirect expected", jump_addr);
        end else begin
          mon_e = exp_q.pop_front();
          chk("jump_addr", jump_addr, mon_e.addr);
          chk("jump_idx", {28'h0, irq_idx}, {28'h0, mon_e.idx});
        end
      end else if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        n_chk++;
        $display("FAIL missed_jump: jump_en=%b expected redirect to %h", jump_en, mon_e.addr);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0]  cur_ir = 8'h00;
  logic        cur_en = 1'b0;
  logic [31:0] cur_ra = 32'h0;

  task automatic step(input logic [1:0] op, input logic [4:0] aw, input logic [31:0] dw,
                      input logic [4:0] ar);
    @(negedge clk);
    oper = op; addr_w = aw; data_w = dw; ir_en = cur_en; ret_addr = cur_ra;
    ir_in = cur_ir; addr_r = ar;
    #1 chk($sformatf("data_r[%0d]", ar), data_r, model_read(ar));
    @(posedge clk);
    model_step(op, aw, dw, cur_en, cur_ra, cur_ir);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 5'd0, 32'h0, 5'(12 + (i % 4)));
  endtask

  task automatic mtc0(input logic [4:0] aw, input logic [31:0] dw);
    step(2'b10, aw, dw, aw);
  endtask

  // Constant check of a register, used right after a step returns (before the next negedge).
  task automatic peek(input logic [4:0] ar, input logic [31:0] exp, input string name);
    addr_r = ar;
    #1 chk(name, data_r, exp);
  endtask

  task automatic peek_jump(input logic en, input logic [31:0] addr, input string name);
    #1;
    chk({name, "_en"}, {31'h0, jump_en}, {31'h0, en});
    if (en) chk({name, "_addr"}, jump_addr, addr);
  endtask

  int          r, r2;
  logic [4:0]  aw, ar;
  logic [31:0] dw;

  initial begin
    rst = 1'b1; oper = 2'b00; addr_r = 5'd0; addr_w = 5'd0; data_w = 32'h0;
    ir_en = 1'b0; ir_in = 8'h00; ret_addr = 32'h0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mon_on = 1;

    // reset values and quiet outputs
    step(2'b01, 5'd0, 32'h0, 5'd15);
    peek(5'd15, 32'h20, "base_reset");
    peek(5'd12, 32'h0, "status_reset");
    peek(5'd13, 32'h0, "cause_reset");
    peek(5'd14, 32'h0, "epc_reset");
    for (int i = 0; i < 10; i++) begin
      step(2'b00, 5'd0, 32'h0, 5'd13);
      peek_jump(1'b0, 32'h0, "quiet_after_reset");
    end

    // level interrupt on line 0
    mtc0(5'd12, 32'h0000_0101);
    cur_ir = 8'h01; cur_en = 1'b1; cur_ra = 32'h100;
    step(2'b00, 5'd0, 32'h0, 5'd13);
    step(2'b00, 5'd0, 32'h0, 5'd13);
    peek_jump(1'b0, 32'h0, "level_not_yet");
    step(2'b00, 5'd0, 32'h0, 5'd13);
    peek_jump(1'b1, 32'h20, "level_take");
    peek(5'd14, 32'h100, "level_epc");
    peek(5'd12, 32'h103, "level_status_exl");
    peek(5'd13, 32'h100, "level_cause");
    step(2'b00, 5'd0, 32'h0, 5'd12);
    peek_jump(1'b0, 32'h0, "level_single_pulse");
    idle(3);

    // ERET with line 0 still high: return, then a fresh take on the following edge
    mtc0(5'd14, 32'h104);
    cur_ra = 32'h200;
    step(2'b11, 5'd0, 32'h0, 5'd14);
    peek_jump(1'b1, 32'h104, "eret_jump");
    peek(5'd12, 32'h101, "eret_exl_clear");
    step(2'b00, 5'd0, 32'h0, 5'd14);
    peek_jump(1'b1, 32'h20, "retake_after_eret");
    peek(5'd14, 32'h200, "retake_epc");
    cur_ir = 8'h00;
    idle(4);
    step(2'b11, 5'd0, 32'h0, 5'd12);
    idle(2);

    // vectored dispatch, lines 3 and 5 together
    mtc0(5'd12, 32'h0000_FF05);
    cur_ir = 8'h28;
    step(2'b00, 5'd0, 32'h0, 5'd13);
    step(2'b00, 5'd0, 32'h0, 5'd13);
    step(2'b00, 5'd0, 32'h0, 5'd13);
    peek_jump(1'b1, 32'h80, "vec_take");
    chk("vec_irq_idx", {28'h0, irq_idx}, 32'd3);
    peek(5'd13, 32'h2803, "vec_cause");
    cur_ir = 8'h00;
    idle(3);
    step(2'b11, 5'd0, 32'h0, 5'd12);
    idle(2);

    // edge line 2: pulse while IE=0, clear with W1C, then enable
    mtc0(5'd12, 32'h0000_0400);
    cur_ir = 8'h04;
    step(2'b00, 5'd0, 32'h0, 5'd13);
    cur_ir = 8'h00;
    idle(5);
    peek(5'd13, 32'h403, "edge_pending_held");
    mtc0(5'd13, 32'h400);
    peek(5'd13, 32'h003, "edge_w1c");
    mtc0(5'd12, 32'h0000_0401);
    for (int i = 0; i < 6; i++) begin
      step(2'b00, 5'd0, 32'h0, 5'd13);
      peek_jump(1'b0, 32'h0, "edge_cleared_no_take");
    end

    // random phase
    for (int k = 0; k < 1500; k++) begin
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 4) == 0) cur_ir = 8'($urandom);
      cur_en = ($urandom_range(0, 9) < 8);
      cur_ra = $urandom & 32'hFFFF_FFFC;
      r2 = $urandom_range(0, 5);
      ar = (r2 < 4) ? 5'(12 + r2) : 5'($urandom_range(0, 31));
      if (r < 8) begin
        step(2'b11, 5'd0, 32'h0, ar);
      end else if (r < 32) begin
        r2 = $urandom_range(0, 9);
        dw = $urandom;
        if (r2 < 4) begin
          aw = 5'd12;
          dw[0] = ($urandom_range(0, 3) != 0);
          dw[1] = ($urandom_range(0, 7) == 0);
        end else if (r2 < 6) aw = 5'd13;
        else if (r2 == 6)    aw = 5'd14;
        else if (r2 == 7)    aw = 5'd15;
        else                 aw = 5'($urandom_range(16, 31));
        step(2'b10, aw, dw, ar);
      end else begin
        step(2'(r % 2), 5'($urandom), $urandom, ar);
      end
    end

    // asynchronous reset while in a handler with edge pending set
    cur_en = 1'b0; cur_ir = 8'h00;
    mtc0(5'd12, 32'h0);
    mtc0(5'd12, 32'h0);
    idle(4);
    mtc0(5'd13, 32'h0000_FF00);
    cur_en = 1'b1; cur_ra = 32'h300;
    mtc0(5'd12, 32'h0000_0401);
    cur_ir = 8'h04;
    step(2'b00, 5'd0, 32'h0, 5'd13);
    cur_ir = 8'h00;
    idle(5);
    peek(5'd13, 32'h402, "pre_reset_cause");
    peek(5'd12, 32'h403, "pre_reset_status");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_jump_en", {31'h0, jump_en}, 32'h0);
    chk("rst_jump_addr", jump_addr, 32'h0);
    chk("rst_irq_idx", {28'h0, irq_idx}, 32'h0);
    addr_r = 5'd12; #1 chk("rst_status", data_r, 32'h0);
    addr_r = 5'd13; #1 chk("rst_cause", data_r, 32'h0);
    addr_r = 5'd14; #1 chk("rst_epc", data_r, 32'h0);
    addr_r = 5'd15; #1 chk("rst_base", data_r, 32'h20);
    model_reset();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    step(2'b00, 5'd0, 32'h0, 5'd13);
    peek(5'd13, 32'h0, "post_reset_pending_lost");
    idle(4);

    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
